// File: rtl/requant_pack.sv
// Requantizes a signed 32-bit accumulator stream to int8 (bias, scale, rounding shift, ReLU, saturate),
// packs four lanes per 32-bit word and queues the words in a first-word-fall-through FIFO.
module requant_pack #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [31:0]              in_data,
   input  logic                     flush,
   input  logic [31:0]              bias,
   input  logic [15:0]              mult,
   input  logic [4:0]               shift,
   input  logic                     relu_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [2:0]               out_lanes,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);

   logic [32:0] s1_reg;
   logic        s1_valid_reg, s1_flush_reg;
   logic [7:0]  s2_q_reg;
   logic        s2_valid_reg, s2_flush_reg;
   logic [1:0]  idx_reg, idx_next;
   logic [23:0] lanes_reg, lanes_next, lanes_ins;

   logic signed [49:0] s1_ext, m_ext, p, rnd, r;
   logic [7:0]  q_next;

   logic        push;
   logic [31:0] push_data;
   logic [2:0]  push_lanes;

   logic [34:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic        overflow_reg;
   logic        full, pop, accept;

   // Stage S1: bias add, widened to 33 bits so it never wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg       <= '0;
         s1_valid_reg <= 1'b0;
         s1_flush_reg <= 1'b0;
      end else begin
         s1_reg       <= {in_data[31], in_data} + {bias[31], bias};
         s1_valid_reg <= in_valid;
         s1_flush_reg <= flush;
      end
   end

   // Stage S2 math: scale, round half toward +inf, optional ReLU, clamp to int8
   always_comb begin
      s1_ext = {{17{s1_reg[32]}}, s1_reg};
      m_ext  = {34'd0, mult};
      p      = s1_ext * m_ext;
      rnd    = '0;
      if (shift != 5'd0)
         rnd = 50'sd1 <<< (shift - 5'd1);
      r = (p + rnd) >>> shift;
      if (relu_en && r < 0)
         r = '0;
      if (r > 50'sd127)
         q_next = 8'h7F;
      else if (r < -50'sd128)
         q_next = 8'h80;
      else
         q_next = r[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_q_reg     <= '0;
         s2_valid_reg <= 1'b0;
         s2_flush_reg <= 1'b0;
      end else begin
         s2_q_reg     <= q_next;
         s2_valid_reg <= s1_valid_reg;
         s2_flush_reg <= s1_flush_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         assign lanes_ins[8*gi +: 8] = (idx_reg == 2'(gi)) ? s2_q_reg : lanes_reg[8*gi +: 8];
      end
   endgenerate

   // Packer: a sample at idx 3 completes the word, so a coincident flush adds nothing
   always_comb begin
      push       = 1'b0;
      push_data  = '0;
      push_lanes = '0;
      idx_next   = idx_reg;
      lanes_next = lanes_reg;
      if (s2_valid_reg) begin
         if (idx_reg == 2'd3) begin
            push       = 1'b1;
            push_data  = {s2_q_reg, lanes_reg};
            push_lanes = 3'd4;
            idx_next   = 2'd0;
            lanes_next = '0;
         end else if (s2_flush_reg) begin
            push       = 1'b1;
            push_data  = {8'd0, lanes_ins};
            push_lanes = {1'b0, idx_reg} + 3'd1;
            idx_next   = 2'd0;
            lanes_next = '0;
         end else begin
            idx_next   = idx_reg + 2'd1;
            lanes_next = lanes_ins;
         end
      end else if (s2_flush_reg && idx_reg != 2'd0) begin
         push       = 1'b1;
         push_data  = {8'd0, lanes_reg};
         push_lanes = {1'b0, idx_reg};
         idx_next   = 2'd0;
         lanes_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg   <= '0;
         lanes_reg <= '0;
      end else begin
         idx_reg   <= idx_next;
         lanes_reg <= lanes_next;
      end
   end

   assign full   = (count_reg == (AW+1)'(DEPTH));
   assign pop    = out_valid && out_ready;
   assign accept = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr_reg] <= {push_lanes, push_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (accept && !pop)
            count_reg <= count_reg + 1'b1;
         else if (pop && !accept)
            count_reg <= count_reg - 1'b1;
         if (push && full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   assign out_valid = (count_reg != '0);
   assign out_data  = out_valid ? mem[rd_ptr_reg][31:0]  : 32'd0;
   assign out_lanes = out_valid ? mem[rd_ptr_reg][34:32] : 3'd0;
   assign level     = count_reg;
   assign overflow  = overflow_reg;
   assign busy      = s1_valid_reg || s2_valid_reg || (idx_reg != 2'd0);

endmodule

// File: doc/requant_pack.md
# requant_pack

Output stage directly downstream of `mac_pipeline`. It takes the signed 32-bit accumulator stream (`y`/`out_valid`), applies bias, fixed-point scale and rounding shift, optional ReLU, and saturation to int8. It packs four int8 results into a 32-bit word and buffers the words in a small FIFO with a ready/valid output. This absorbs backpressure, since `mac_pipeline` has no stall input.

## Interface
Parameters:
- `DEPTH`, default 4: output FIFO depth in 32-bit words. Power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  sample valid; driven from `mac_pipeline.out_valid`
- `in_data`  in  32  signed accumulator; driven from `mac_pipeline.y`
- `flush`  in  1  end-of-vector marker; may coincide with `in_valid` or arrive alone
- `bias`  in  32  signed bias
- `mult`  in  16  unsigned scale multiplier
- `shift`  in  5  right-shift amount, 0..31
- `relu_en`  in  1  clamp negatives to 0
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  32  packed word; lane i occupies bits [8i+7:8i]
- `out_lanes`  out  3  number of valid lanes in word, 1..4
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky: a word was dropped
- `busy`  out  1  S1 or S2 valid, or packer lane index ≠ 0

## Operation
- Stage S1 (register): `s1 = sext33(in_data) + sext33(bias)`. Carries `valid` and `flush` flags.
- Stage S2 (register): computes int8 `q` from S1:
  - `p = s1 * mult`, 49-bit signed; `mult` is zero-extended.
  - Rounding: `shift==0` gives `r = p`. Otherwise `r = (p + 2^(shift-1)) >>> shift` (round half toward +inf).
  - ReLU: if `relu_en` and `r<0`, then `r=0`.
  - Saturation: clamp `r` to [-128,127] to give `q`. Flags carry through to S2.
- Packer: lane index `idx` 0..3, plus a 24-bit lane holding register.
  - S2 valid with `idx<3`: store `q` in lane `idx`, then `idx++`.
  - S2 valid with `idx==3`: push `{q, lanes2..0}` with `out_lanes=4`, then `idx=0`.
  - S2 flush after the sample is handled, with `idx>0`: push the partial word. Unused upper lanes are 0 and `out_lanes=idx`. Then `idx=0`. A flush when `idx==0` with no sample pushes nothing.
  - S2 valid+flush with `idx==3`: push a single full word, not two.
  - The holding register is cleared after every push.
- FIFO: first-word-fall-through.
  - Pop occurs when `out_valid && out_ready`.
  - A push when full with no pop in the same cycle drops the word and sets `overflow`. Only `rst` clears `overflow`.
  - A push and pop in the same cycle while full are both accepted; `level` is unchanged.
  - A push and pop in the same cycle while empty: the word is stored, and `out_valid` rises the next cycle.
- `out_data`/`out_lanes` are 0 whenever `out_valid=0`.
- Config timing: `bias` is sampled at S1 and `mult`/`shift`/`relu_en` at S2. They must be stable while `busy`; behaviour is otherwise undefined per sample.

## Timing
- Reset: on `rst`, all state clears on the next edge.
  - `out_valid=0`, `out_data=0`, `out_lanes=0`, `level=0`, `overflow=0`, `busy=0`.
  - `idx=0`; S1/S2 are invalid.
- `rst` has priority over all other inputs. Reset mid-word discards partial lanes and FIFO contents.
- Sample timing: the sample presented in cycle N enters S1 at edge N and S2 at edge N+1, and is packed or pushed at edge N+2.
- Word completed by the sample in cycle N: `out_valid` is high in cycle N+3 if the FIFO was empty. Latency is 3 cycles.
- Throughput: one sample per cycle, with no input stall.

## Test plan
- Identity (`bias=0`, `mult=1`, `shift=0`, `relu_en=0`): inputs 22, -9, 64, 300 back-to-back -> `out_data=0x7F40F716`, `out_lanes=4`, `out_valid` 3 cycles after the 4th input.
- Rounding/saturation (`bias=1`, `mult=3`, `shift=2`): inputs 10, -10, 5, -200 -> lanes 8, -7, 5, -128 -> `0x8005F908`.
- ReLU plus partial flush (identity, `relu_en=1`): input -5, then 7 with `flush` -> `0x00000700`, `out_lanes=2`, `idx` back to 0. A lone `flush` afterwards -> no word.
- Overflow (`DEPTH=4`, `out_ready=0`): 20 samples (5 words) -> `level=4`, `overflow=1`, first 4 words retained. Then `out_ready=1` -> those 4 words drain in order, and `overflow` stays 1.
- Full with simultaneous push and pop: FIFO holding 4 words, `out_ready=1` during a push -> `level` stays 4, `overflow` stays 0, and order is preserved.
- Reset mid-operation: `rst` after 2 samples and with 2 words queued -> next cycle `out_valid=0`, `level=0`, `busy=0`. The next 4 identity samples 1, 2, 3, 4 -> `0x04030201`.
